// File: rtl/nonce_pkg.sv
// Shared constants and nonce-correction helpers for the nonce arbiter.
// Correction: bit-reverse the raw nonce, then subtract the pipeline offset (mod 2^32).
package nonce_pkg;
  localparam int              NONCE_W          = 32;
  localparam logic [32-1:0]   NONCE_OFFSET_DEF = 32'h0000_00c0;

  function automatic logic [NONCE_W-1:0] bitrev32(input logic [NONCE_W-1:0] v);
    logic [NONCE_W-1:0] r;
    r = {NONCE_W{1'b0}};
    for (int b = 0; b < NONCE_W; b++) begin
      r[NONCE_W-1-b] = v[b];
    end
    return r;
  endfunction

  function automatic logic [NONCE_W-1:0] nonce_correct(input logic [NONCE_W-1:0] raw,
                                                       input logic [NONCE_W-1:0] offset);
    return bitrev32(raw) - offset;
  endfunction
endpackage

// File: rtl/nonce_arbiter_if.sv
// Core-report / result-stream bundle for nonce_arbiter.
// slave = arbiter side, master = work-control and result-consumer side.
interface nonce_arbiter_if
  import nonce_pkg::*;
#(
  parameter int NCORES = 2
);
  localparam int CW = $clog2(NCORES);

  logic                      flush;
  logic [NCORES-1:0]         core_valid;
  logic [NONCE_W*NCORES-1:0] core_nonce;
  logic                      out_valid;
  logic                      out_ready;
  logic [NONCE_W-1:0]        out_nonce;
  logic [CW-1:0]             out_core;
  logic                      drop_flag;
  logic [7:0]                drop_cnt;

  modport slave (
    input  flush, core_valid, core_nonce, out_ready,
    output out_valid, out_nonce, out_core, drop_flag, drop_cnt
  );

  modport master (
    output flush, core_valid, core_nonce, out_ready,
    input  out_valid, out_nonce, out_core, drop_flag, drop_cnt
  );
endinterface

// File: rtl/nonce_fifo.sv
// First-word-fall-through result FIFO with async reset and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module nonce_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rptr];

  // Storage, pointers and occupancy; clear wipes contents so no stale entry reappears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {(AW+1){1'b0}};
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/nonce_arbiter.sv
// Round-robin collection of golden nonces from NCORES cores into a corrected result FIFO.
// Optional macro NONCE_BITREV_OUT_EN: re-reverse out_nonce back into the core's bit order.
module nonce_arbiter
  import nonce_pkg::*;
#(
  parameter int                 NCORES       = 2,
  parameter int                 FIFO_DEPTH   = 4,
  parameter logic [NONCE_W-1:0] NONCE_OFFSET = NONCE_OFFSET_DEF
) (
  input  logic            clk,
  input  logic            rst,
  nonce_arbiter_if.slave  bus
);
  localparam int              CW      = $clog2(NCORES);
  localparam int              FW      = NONCE_W + CW;
  localparam logic [CW-1:0]   PTR_RST = CW'(NCORES - 1);

  logic [NCORES-1:0]  r_pend_vld;
  logic [NONCE_W-1:0] r_pend_nonce [NCORES];
  logic [CW-1:0]      r_ptr;
  logic               r_drop_flag;
  logic [7:0]         r_drop_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_grant;
  logic [CW-1:0]      w_win;
  logic [NONCE_W-1:0] w_corr;
  logic [FW-1:0]      w_rd_data;
  logic [15:0]        w_drops;
  logic [15:0]        w_drop_sum;

  // Round-robin winner search from ptr+1; no grant when full or flushing.
  always_comb begin
    w_grant = 1'b0;
    w_win   = {CW{1'b0}};
    for (int k = 1; k <= NCORES; k++) begin
      if (!w_grant && !w_full && !bus.flush && r_pend_vld[(int'(r_ptr) + k) % NCORES]) begin
        w_grant = 1'b1;
        w_win   = CW'((int'(r_ptr) + k) % NCORES);
      end
    end
  end

  // Count reports that arrive while the core's previous result is still waiting.
  always_comb begin
    w_drops = 16'd0;
    for (int i = 0; i < NCORES; i++) begin
      if (bus.core_valid[i] && r_pend_vld[i] && !(w_grant && (w_win == CW'(i)))) begin
        w_drops = w_drops + 16'd1;
      end
    end
    w_drop_sum = {8'd0, r_drop_cnt} + w_drops;
  end

  assign w_corr = nonce_correct(r_pend_nonce[w_win], NONCE_OFFSET);

  // Pending capture, RR pointer and drop accounting; granted core may capture anew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_vld <= {NCORES{1'b0}};
      for (int i = 0; i < NCORES; i++) begin
        r_pend_nonce[i] <= {NONCE_W{1'b0}};
      end
      r_ptr       <= PTR_RST;
      r_drop_flag <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else if (bus.flush) begin
      r_pend_vld  <= {NCORES{1'b0}};
      r_ptr       <= PTR_RST;
      r_drop_flag <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (bus.core_valid[i] && (!r_pend_vld[i] || (w_grant && (w_win == CW'(i))))) begin
          r_pend_nonce[i] <= bus.core_nonce[NONCE_W*i +: NONCE_W];
          r_pend_vld[i]   <= 1'b1;
        end else if (w_grant && (w_win == CW'(i))) begin
          r_pend_vld[i] <= 1'b0;
        end
      end
      if (w_grant) begin
        r_ptr <= w_win;
      end
      if (w_drops != 16'd0) begin
        r_drop_flag <= 1'b1;
        r_drop_cnt  <= (w_drop_sum > 16'd255) ? 8'd255 : w_drop_sum[7:0];
      end
    end
  end

  nonce_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (bus.flush),
    .i_wr_en   (w_grant),
    .i_wr_data ({w_win, w_corr}),
    .i_rd_en   (!w_empty && bus.out_ready),
    .o_rd_data (w_rd_data),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_core  = w_rd_data[FW-1:NONCE_W];
`ifdef NONCE_BITREV_OUT_EN
  assign bus.out_nonce = bitrev32(w_rd_data[NONCE_W-1:0]);
`else
  assign bus.out_nonce = w_rd_data[NONCE_W-1:0];
`endif
  assign bus.drop_flag = r_drop_flag;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_nonce_arbiter.sv
// Directed + randomized bench for nonce_arbiter against a queue-based reference model.
module tb_nonce_arbiter;
  localparam int          NC    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] OFF   = 32'h0000_00c0;
`ifdef NONCE_BITREV_OUT_EN
  localparam logic [31:0] E_N3   = 32'h02FF_FFFD;
  localparam logic [31:0] E_N0   = 32'h02FF_FFFF;
  localparam logic [31:0] E_NTOP = 32'h0000_0000;
`else
  localparam logic [31:0] E_N3   = 32'hBFFF_FF40;
  localparam logic [31:0] E_N0   = 32'hFFFF_FF40;
  localparam logic [31:0] E_NTOP = 32'h0000_0000;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  nonce_arbiter_if #(.NCORES(NC)) bus ();

  nonce_arbiter #(
    .NCORES       (NC),
    .FIFO_DEPTH   (DEPTH),
    .NONCE_OFFSET (OFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] n; int c; } ent_t;
  ent_t        m_q[$];
  bit          m_pv [NC];
  logic [31:0] m_pn [NC];
  int          m_ptr;
  bit          m_df;
  int          m_dc;

  function automatic logic [31:0] m_correct(input logic [31:0] raw);
    longint r;
    r = 0;
    for (int b = 0; b < 32; b++) r = (r << 1) | ((longint'(raw) >> b) & 1);
    return 32'(r - longint'(OFF));
  endfunction

  function automatic logic [31:0] m_view(input logic [31:0] stored);
`ifdef NONCE_BITREV_OUT_EN
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[31-b] = stored[b];
    return r;
`else
    return stored;
`endif
  endfunction

  function automatic logic [32*NC-1:0] pk(input logic [31:0] a, input logic [31:0] b);
    return {b, a};
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NC; i++) begin m_pv[i] = 1'b0; m_pn[i] = 32'd0; end
    m_ptr = NC - 1;
    m_df  = 1'b0;
    m_dc  = 0;
  endtask

  task automatic model_update(input logic [NC-1:0] cv, input logic [32*NC-1:0] cn,
                              input bit rdy, input bit fl);
    int win;
    if (fl) begin
      m_q.delete();
      for (int i = 0; i < NC; i++) m_pv[i] = 1'b0;
      m_ptr = NC - 1;
      m_df  = 1'b0;
      m_dc  = 0;
    end else begin
      win = -1;
      if (m_q.size() < DEPTH)
        for (int k = 1; k <= NC; k++)
          if (win < 0 && m_pv[(m_ptr + k) % NC]) win = (m_ptr + k) % NC;
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (win >= 0) begin
        m_q.push_back('{m_correct(m_pn[win]), win});
        m_pv[win] = 1'b0;
        m_ptr     = win;
      end
      for (int i = 0; i < NC; i++) begin
        if (cv[i]) begin
          if (!m_pv[i]) begin
            m_pn[i] = cn[32*i +: 32];
            m_pv[i] = 1'b1;
          end else begin
            m_df = 1'b1;
            if (m_dc < 255) m_dc++;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    chk("drop_flag", 32'(bus.drop_flag), 32'(m_df));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_dc));
    if (m_q.size() > 0) begin
      chk("out_nonce", bus.out_nonce, m_view(m_q[0].n));
      chk("out_core",  32'(bus.out_core), 32'(m_q[0].c));
    end
  endtask

  task automatic step(input logic [NC-1:0] cv, input logic [32*NC-1:0] cn,
                      input bit rdy, input bit fl);
    bus.core_valid = cv;
    bus.core_nonce = cn;
    bus.out_ready  = rdy;
    bus.flush      = fl;
    @(posedge clk);
    model_update(cv, cn, rdy, fl);
    #1;
    bus.core_valid = '0;
    bus.flush      = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic single(input int c, input logic [31:0] n, input logic [31:0] exp, input string tag);
    step(NC'(1 << c), (c == 0) ? pk(n, 32'd0) : pk(32'd0, n), 1'b1, 1'b0);
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    step('0, '0, 1'b0, 1'b0);
    chk({tag, "_nonce"}, bus.out_nonce, exp);
    chk({tag, "_core"}, 32'(bus.out_core), 32'(c));
    step('0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    bus.flush      = 1'b0;
    bus.core_valid = '0;
    bus.core_nonce = '0;
    bus.out_ready  = 1'b0;
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_nonce", bus.out_nonce, 32'd0);
    chk("rst_core",  32'(bus.out_core), 32'd0);
    chk("rst_dflag", 32'(bus.drop_flag), 32'd0);
    chk("rst_dcnt",  32'(bus.drop_cnt), 32'd0);

    single(0, 32'h0000_0003, E_N3, "n3");
    single(0, 32'h0000_0000, E_N0, "n0");
    single(1, 32'h0300_0000, E_NTOP, "ntop");

    // Simultaneous pulses after reset, twice: core0 wins both rounds.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      step(2'b11, pk($urandom, $urandom), 1'b1, 1'b0);
      step('0, '0, 1'b1, 1'b0);
      chk("rr_first", 32'(bus.out_core), 32'd0);
      step('0, '0, 1'b1, 1'b0);
      chk("rr_second", 32'(bus.out_core), 32'd1);
      step('0, '0, 1'b1, 1'b0);
    end

    // Backpressure: five results, FIFO fills, core1 re-pulses while pending.
    for (int i = 0; i < 5; i++)
      step((i % 2 == 0) ? 2'b10 : 2'b01, pk($urandom, $urandom), 1'b0, 1'b0);
    repeat (2) step('0, '0, 1'b0, 1'b0);
    step(2'b10, pk($urandom, $urandom), 1'b0, 1'b0);
    chk("bp_dflag", 32'(bus.drop_flag), 32'd1);
    chk("bp_dcnt",  32'(bus.drop_cnt), 32'd1);
    repeat (8) step('0, '0, 1'b1, 1'b0);

    // Flush with full FIFO and pending work.
    for (int i = 0; i < 6; i++)
      step((i % 2 == 0) ? 2'b01 : 2'b10, pk($urandom, $urandom), 1'b0, 1'b0);
    step(2'b11, pk($urandom, $urandom), 1'b0, 1'b0);
    step(2'b11, pk($urandom, $urandom), 1'b0, 1'b1);
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_dcnt",  32'(bus.drop_cnt), 32'd0);
    begin
      logic [31:0] n;
      n = $urandom;
      single(1, n, m_view(m_correct(n)), "post_flush");
    end

    // Randomized traffic.
    for (int i = 0; i < 80; i++)
      step(NC'($urandom_range(0, 3)), pk($urandom, $urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
    repeat (6) step('0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    step(2'b11, pk($urandom, $urandom), 1'b0, 1'b0);
    repeat (2) step('0, '0, 1'b0, 1'b0);
    chk("pre_arst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_nonce", bus.out_nonce, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    single(0, 32'h0000_0003, E_N3, "arst_n3");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
